// File: rtl/tlb_array.sv
// Fully associative dual-page joint TLB: two independent combinational search
// ports, one write port and one combinational read port over flop-based entries.
module tlb_array #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [18:0]     s0_vpn2,
  input  logic            s0_odd_page,
  input  logic [7:0]      s0_asid,
  output logic            s0_found,
  output logic [IDXW-1:0] s0_index,
  output logic [19:0]     s0_pfn,
  output logic [2:0]      s0_c,
  output logic            s0_d,
  output logic            s0_v,
  input  logic [18:0]     s1_vpn2,
  input  logic            s1_odd_page,
  input  logic [7:0]      s1_asid,
  output logic            s1_found,
  output logic [IDXW-1:0] s1_index,
  output logic [19:0]     s1_pfn,
  output logic [2:0]      s1_c,
  output logic            s1_d,
  output logic            s1_v,
  input  logic            we,
  input  logic [IDXW-1:0] w_index,
  input  logic [18:0]     w_vpn2,
  input  logic [7:0]      w_asid,
  input  logic            w_g,
  input  logic [19:0]     w_pfn0,
  input  logic [2:0]      w_c0,
  input  logic            w_d0,
  input  logic            w_v0,
  input  logic [19:0]     w_pfn1,
  input  logic [2:0]      w_c1,
  input  logic            w_d1,
  input  logic            w_v1,
  input  logic [IDXW-1:0] r_index,
  output logic [18:0]     r_vpn2,
  output logic [7:0]      r_asid,
  output logic            r_g,
  output logic [19:0]     r_pfn0,
  output logic [2:0]      r_c0,
  output logic            r_d0,
  output logic            r_v0,
  output logic [19:0]     r_pfn1,
  output logic [2:0]      r_c1,
  output logic            r_d1,
  output logic            r_v1
);

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } entry_t;

  entry_t entry_q [TLBNUM];
  logic   e_q     [TLBNUM];
  entry_t w_entry_d;

  assign w_entry_d = '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                       pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                       pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};

  // Reset takes priority over a concurrent write, so nothing survives it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < TLBNUM; i++) begin
      if (reset) begin
        entry_q[i] <= '0;
        e_q[i]     <= 1'b0;
      end else if (we && (w_index == IDXW'(i))) begin
        entry_q[i] <= w_entry_d;
        e_q[i]     <= 1'b1;
      end
    end
  end

  // Read port sees stored state only, so an entry being written reads old data.
  assign r_vpn2 = entry_q[r_index].vpn2;
  assign r_asid = entry_q[r_index].asid;
  assign r_g    = entry_q[r_index].g;
  assign r_pfn0 = entry_q[r_index].pfn0;
  assign r_c0   = entry_q[r_index].c0;
  assign r_d0   = entry_q[r_index].d0;
  assign r_v0   = entry_q[r_index].v0;
  assign r_pfn1 = entry_q[r_index].pfn1;
  assign r_c1   = entry_q[r_index].c1;
  assign r_d1   = entry_q[r_index].d1;
  assign r_v1   = entry_q[r_index].v1;

  logic [18:0]     s_vpn2  [2];
  logic            s_odd   [2];
  logic [7:0]      s_asid  [2];
  logic            s_found [2];
  logic [IDXW-1:0] s_index [2];
  logic [19:0]     s_pfn   [2];
  logic [2:0]      s_c     [2];
  logic            s_d     [2];
  logic            s_v     [2];

  assign s_vpn2[0] = s0_vpn2;
  assign s_odd[0]  = s0_odd_page;
  assign s_asid[0] = s0_asid;
  assign s_vpn2[1] = s1_vpn2;
  assign s_odd[1]  = s1_odd_page;
  assign s_asid[1] = s1_asid;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [TLBNUM-1:0] match;
      logic [IDXW-1:0]   idx;
      entry_t            sel;

      always_comb begin
        match = '0;
        for (int i = 0; i < TLBNUM; i++) begin
          match[i] = e_q[i] && (entry_q[i].vpn2 == s_vpn2[gi]) &&
                     (entry_q[i].g || (entry_q[i].asid == s_asid[gi]));
        end
      end

      // Scan downward so the lowest matching index wins a multiple match.
      always_comb begin
        idx = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
          if (match[i]) idx = IDXW'(i);
        end
      end

      assign sel = entry_q[idx];

      always_comb begin
        s_found[gi] = |match;
        s_index[gi] = idx;
        s_pfn[gi]   = '0;
        s_c[gi]     = '0;
        s_d[gi]     = 1'b0;
        s_v[gi]     = 1'b0;
        if (|match) begin
          s_pfn[gi] = s_odd[gi] ? sel.pfn1 : sel.pfn0;
          s_c[gi]   = s_odd[gi] ? sel.c1   : sel.c0;
          s_d[gi]   = s_odd[gi] ? sel.d1   : sel.d0;
          s_v[gi]   = s_odd[gi] ? sel.v1   : sel.v0;
        end
      end
    end
  endgenerate

  assign s0_found = s_found[0];
  assign s0_index = s_index[0];
  assign s0_pfn   = s_pfn[0];
  assign s0_c     = s_c[0];
  assign s0_d     = s_d[0];
  assign s0_v     = s_v[0];
  assign s1_found = s_found[1];
  assign s1_index = s_index[1];
  assign s1_pfn   = s_pfn[1];
  assign s1_c     = s_c[1];
  assign s1_d     = s_d[1];
  assign s1_v     = s_v[1];

endmodule

// File: tb/tb_tlb_array.sv
// Directed bench for tlb_array: search, page select, ASID/global match,
// write visibility timing, duplicate priority and reset over a write.
module tb_tlb_array;
  localparam int TLBNUM = 16;
  localparam int IDXW   = 4;

  logic clk = 1'b0;
  logic reset;
  logic [18:0] s0_vpn2, s1_vpn2;
  logic s0_odd_page, s1_odd_page;
  logic [7:0] s0_asid, s1_asid;
  logic s0_found, s1_found;
  logic [IDXW-1:0] s0_index, s1_index;
  logic [19:0] s0_pfn, s1_pfn;
  logic [2:0] s0_c, s1_c;
  logic s0_d, s0_v, s1_d, s1_v;
  logic we;
  logic [IDXW-1:0] w_index, r_index;
  logic [18:0] w_vpn2, r_vpn2;
  logic [7:0] w_asid, r_asid;
  logic w_g, r_g;
  logic [19:0] w_pfn0, w_pfn1, r_pfn0, r_pfn1;
  logic [2:0] w_c0, w_c1, r_c0, r_c1;
  logic w_d0, w_v0, w_d1, w_v1, r_d0, r_v0, r_d1, r_v1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tlb_array #(.TLBNUM(TLBNUM), .IDXW(IDXW)) dut (
    .clk(clk), .reset(reset),
    .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
    .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
    .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_write(input logic [IDXW-1:0] idx, input logic [18:0] vpn2,
                           input logic [7:0] asid, input logic g,
                           input logic [19:0] pfn0, input logic [2:0] c0, input logic d0, input logic v0,
                           input logic [19:0] pfn1, input logic [2:0] c1, input logic d1, input logic v1);
    we = 1'b1; w_index = idx; w_vpn2 = vpn2; w_asid = asid; w_g = g;
    w_pfn0 = pfn0; w_c0 = c0; w_d0 = d0; w_v0 = v0;
    w_pfn1 = pfn1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
  endtask

  task automatic search1(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
    s1_vpn2 = vpn2; s1_odd_page = odd; s1_asid = asid;
    #1;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0;
    s0_vpn2 = '0; s0_odd_page = 1'b0; s0_asid = '0;
    s1_vpn2 = '0; s1_odd_page = 1'b0; s1_asid = '0;
    r_index = '0;
    set_write(4'd0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    we = 1'b0;
    tick(); tick();

    // Reset state
    search1(19'h0, 1'b0, 8'h00);
    check("rst_s1_found", 32'(s1_found), 32'd0);
    check("rst_s1_pfn", 32'(s1_pfn), 32'd0);
    check("rst_s1_index", 32'(s1_index), 32'd0);
    check("rst_s0_found", 32'(s0_found), 32'd0);
    r_index = 4'd3; #1;
    check("rst_r_fields", {r_vpn2, r_asid, r_g, r_v0, r_v1, r_d0, r_d1}, 32'd0);
    check("rst_r_pfn", {r_pfn0[15:0], r_pfn1[15:0]}, 32'd0);
    reset = 1'b0;
    tick();

    // Basic write at idx 3 and page select
    set_write(4'd3, 19'h12345, 8'h05, 1'b0, 20'h00AAA, 3'd3, 1'b0, 1'b1,
              20'h00BBB, 3'd3, 1'b1, 1'b1);
    tick();
    we = 1'b0;
    search1(19'h12345, 1'b1, 8'h05);
    check("odd_found", 32'(s1_found), 32'd1);
    check("odd_index", 32'(s1_index), 32'd3);
    check("odd_pfn", 32'(s1_pfn), 32'h00BBB);
    check("odd_d", 32'(s1_d), 32'd1);
    check("odd_v", 32'(s1_v), 32'd1);
    check("odd_c", 32'(s1_c), 32'd3);
    search1(19'h12345, 1'b0, 8'h05);
    check("even_pfn", 32'(s1_pfn), 32'h00AAA);
    check("even_d", 32'(s1_d), 32'd0);
    check("even_v", 32'(s1_v), 32'd1);
    r_index = 4'd3; #1;
    check("r3_vpn2", 32'(r_vpn2), 32'h12345);
    check("r3_asid", 32'(r_asid), 32'h05);

    // ASID mismatch, then global rewrite
    search1(19'h12345, 1'b0, 8'h06);
    check("asid_miss_found", 32'(s1_found), 32'd0);
    check("asid_miss_pfn", 32'(s1_pfn), 32'd0);
    set_write(4'd3, 19'h12345, 8'h05, 1'b1, 20'h00AAA, 3'd3, 1'b0, 1'b1,
              20'h00BBB, 3'd3, 1'b1, 1'b1);
    tick();
    we = 1'b0; #1;
    check("global_found", 32'(s1_found), 32'd1);
    check("global_pfn", 32'(s1_pfn), 32'h00AAA);

    // Write is not visible in its own cycle; both ports behave the same
    set_write(4'd7, 19'h00100, 8'h00, 1'b0, 20'h00777, 3'd2, 1'b1, 1'b0,
              20'h00778, 3'd1, 1'b0, 1'b1);
    s0_vpn2 = 19'h00100; s0_odd_page = 1'b0; s0_asid = 8'h00;
    search1(19'h00100, 1'b1, 8'h00);
    r_index = 4'd7; #1;
    check("wtime_s1_before", 32'(s1_found), 32'd0);
    check("wtime_s0_before", 32'(s0_found), 32'd0);
    check("wtime_r_old", 32'(r_vpn2), 32'd0);
    tick();
    we = 1'b0; #1;
    check("wtime_s1_after", 32'(s1_found), 32'd1);
    check("wtime_s1_index", 32'(s1_index), 32'd7);
    check("wtime_s1_pfn", 32'(s1_pfn), 32'h00778);
    check("wtime_s0_after", 32'(s0_found), 32'd1);
    check("wtime_s0_index", 32'(s0_index), 32'd7);
    // Valid-bit-clear page still reports a hit
    check("wtime_s0_pfn", 32'(s0_pfn), 32'h00777);
    check("wtime_s0_v", 32'(s0_v), 32'd0);
    check("wtime_s0_d", 32'(s0_d), 32'd1);

    // Duplicate entries: lowest index wins
    set_write(4'd9, 19'h00042, 8'h11, 1'b1, 20'h00999, 3'd1, 1'b0, 1'b1,
              20'h0099A, 3'd1, 1'b0, 1'b1);
    tick();
    search1(19'h00042, 1'b0, 8'h77);
    check("dup_single_index", 32'(s1_index), 32'd9);
    set_write(4'd2, 19'h00042, 8'h22, 1'b1, 20'h00222, 3'd4, 1'b1, 1'b1,
              20'h00223, 3'd4, 1'b1, 1'b1);
    tick();
    we = 1'b0; #1;
    check("dup_found", 32'(s1_found), 32'd1);
    check("dup_index", 32'(s1_index), 32'd2);
    check("dup_pfn", 32'(s1_pfn), 32'h00222);
    check("dup_c", 32'(s1_c), 32'd4);
    // Port 0 still hits idx 7 independently in the same cycle
    check("dup_s0_index", 32'(s0_index), 32'd7);
    r_index = 4'd9; #1;
    check("dup_r9_pfn0", 32'(r_pfn0), 32'h00999);
    check("dup_r9_asid", 32'(r_asid), 32'h11);
    check("dup_r9_g", 32'(r_g), 32'd1);

    // Reset together with a write: reset wins, everything cleared
    set_write(4'd5, 19'h00555, 8'h00, 1'b1, 20'h00555, 3'd5, 1'b1, 1'b1,
              20'h00556, 3'd5, 1'b1, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0; we = 1'b0;
    search1(19'h00042, 1'b0, 8'h00);
    check("rst2_s1_found", 32'(s1_found), 32'd0);
    check("rst2_s1_index", 32'(s1_index), 32'd0);
    check("rst2_s0_found", 32'(s0_found), 32'd0);
    search1(19'h00555, 1'b0, 8'h00);
    check("rst2_w5_found", 32'(s1_found), 32'd0);
    r_index = 4'd5; #1;
    check("rst2_r5_vpn2", 32'(r_vpn2), 32'd0);
    check("rst2_r5_pfn0", 32'(r_pfn0), 32'd0);
    check("rst2_r5_v", {r_g, r_v0, r_v1, r_d0, r_d1}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
